// File: rtl/round_controller_pkg.sv
// Shared types and constants for the Memory Matrix round controller.
package memmatrix_pkg;

    // Round sequencing states; encoding is fixed so debug probes read consistently.
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_LOAD = 4'd1,
        ST_SHOW = 4'd2,
        ST_PLAY = 4'd3,
        ST_WIN  = 4'd4,
        ST_LOSE = 4'd5
    } state_t;

    // Board width: one bit per tile / button.
    localparam int BOARD_W = 8;

    // Feedback taps for x^8 + x^6 + x^5 + x^4 + 1.
    localparam logic [BOARD_W-1:0] LFSR_TAPS = 8'hB8;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [BOARD_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    // Increment that sticks at 15 instead of wrapping.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/round_controller_if.sv
// Button inputs and board/status outputs of the round controller.
interface round_controller_if;
    import memmatrix_pkg::*;

    logic               start;
    logic [BOARD_W-1:0] guess_btn;
    logic [BOARD_W-1:0] solution_board;
    logic [BOARD_W-1:0] found_board;
    logic               show_solution;
    logic               flash_en;
    logic [3:0]         guesses_left;
    logic [3:0]         level;
    logic               win;
    logic               lose;
    logic               busy;

    // Player-side view: drives the buttons, watches the boards.
    modport master (
        output start, guess_btn,
        input  solution_board, found_board, show_solution, flash_en,
               guesses_left, level, win, lose, busy
    );

    // Controller-side view.
    modport slave (
        input  start, guess_btn,
        output solution_board, found_board, show_solution, flash_en,
               guesses_left, level, win, lose, busy
    );
endinterface

// File: rtl/round_controller_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used to pick each round's pattern.
module lfsr8
    import memmatrix_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [BOARD_W-1:0] seed,
    output logic [BOARD_W-1:0] q
);

    logic [BOARD_W-1:0] r_q;
    logic [BOARD_W-1:0] w_seed_safe;
    logic               w_fb;

    // An all-zero seed would lock the register, so it is promoted to 1.
    assign w_seed_safe = (seed == '0) ? 8'h01 : seed;
    assign w_fb        = ^(r_q & LFSR_TAPS);
    assign q           = r_q;

    // Shift every cycle regardless of game state; player timing picks the phase.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q <= w_seed_safe;
        end else begin
            r_q <= {r_q[BOARD_W-2:0], w_fb};
        end
    end

endmodule

// File: rtl/round_controller.sv
// Sequences a Memory Matrix round: load pattern, timed display, guessing, win/lose.
module round_controller
    import memmatrix_pkg::*;
#(
    parameter int unsigned DISPLAY_CYCLES = 50_000_000,
    parameter int unsigned MAX_GUESSES    = 3,
    parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    round_controller_if.slave bus
);

    localparam logic [31:0] TIMER_LOAD = 32'(DISPLAY_CYCLES - 1);
    localparam logic [3:0]  GUESS_INIT = 4'(MAX_GUESSES);

    state_t             r_state;
    logic [BOARD_W-1:0] r_solution;
    logic [BOARD_W-1:0] r_found;
    logic [3:0]         r_guesses;
    logic [3:0]         r_level;
    logic [31:0]        r_timer;
    logic               r_show;
    logic               r_flash;
    logic               r_win;
    logic               r_lose;
    logic               r_busy;
    logic               r_start_q;
    logic [BOARD_W-1:0] r_btn_q;

    logic [BOARD_W-1:0] w_lfsr;
    logic [BOARD_W-1:0] w_press;
    logic [BOARD_W-1:0] w_found_next;
    logic               w_start_edge;
    logic               w_press_valid;
    logic               w_hit;

    lfsr8 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .q     (w_lfsr)
    );

    // Per-button rising-edge detect.
    genvar gi;
    generate
        for (gi = 0; gi < BOARD_W; gi++) begin : g_press
            assign w_press[gi] = bus.guess_btn[gi] & ~r_btn_q[gi];
        end
    endgenerate

    assign w_start_edge  = bus.start & ~r_start_q;
    // Multi-button chords and re-presses of found tiles cost nothing.
    assign w_press_valid = is_onehot(w_press) && ((w_press & r_found) == '0);
    assign w_hit         = (w_press & r_solution) != '0;
    assign w_found_next  = r_found | w_press;

    // Delay copies of the raw inputs for edge detection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_start_q <= 1'b0;
            r_btn_q   <= '0;
        end else begin
            r_start_q <= bus.start;
            r_btn_q   <= bus.guess_btn;
        end
    end

    // Round FSM; status outputs are set on the transition into each state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_solution <= '0;
            r_found    <= '0;
            r_guesses  <= GUESS_INIT;
            r_level    <= 4'd0;
            r_timer    <= '0;
            r_show     <= 1'b0;
            r_flash    <= 1'b1;
            r_win      <= 1'b0;
            r_lose     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_edge) begin
                        r_state <= ST_LOAD;
                        r_flash <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end

                ST_LOAD: begin
                    r_solution <= w_lfsr;
                    r_found    <= '0;
                    r_guesses  <= GUESS_INIT;
                    r_timer    <= TIMER_LOAD;
                    r_state    <= ST_SHOW;
                    r_show     <= 1'b1;
                end

                ST_SHOW: begin
                    // Loaded with N-1, so the display lasts exactly N cycles.
                    if (r_timer == '0) begin
                        r_state <= ST_PLAY;
                        r_show  <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 32'd1;
                    end
                end

                ST_PLAY: begin
                    if (w_press_valid) begin
                        if (w_hit) begin
                            r_found <= w_found_next;
                            if (w_found_next == r_solution) begin
                                r_state <= ST_WIN;
                                r_level <= sat_inc4(r_level);
                                r_win   <= 1'b1;
                                r_flash <= 1'b1;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            if (r_guesses != 4'd0) begin
                                r_guesses <= r_guesses - 4'd1;
                            end
                            if (r_guesses <= 4'd1) begin
                                r_state <= ST_LOSE;
                                r_lose  <= 1'b1;
                                r_flash <= 1'b1;
                                r_show  <= 1'b1;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                end

                ST_WIN: begin
                    if (w_start_edge) begin
                        r_state <= ST_LOAD;
                        r_win   <= 1'b0;
                        r_flash <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end

                ST_LOSE: begin
                    if (w_start_edge) begin
                        r_state <= ST_IDLE;
                        r_level <= 4'd0;
                        r_lose  <= 1'b0;
                        r_show  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_show  <= 1'b0;
                    r_flash <= 1'b1;
                    r_win   <= 1'b0;
                    r_lose  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.solution_board = r_solution;
    assign bus.found_board    = r_found;
    assign bus.show_solution  = r_show;
    assign bus.flash_en       = r_flash;
    assign bus.guesses_left   = r_guesses;
    assign bus.level          = r_level;
    assign bus.win            = r_win;
    assign bus.lose           = r_lose;
    assign bus.busy           = r_busy;

endmodule

// File: tb/tb_round_controller.sv
// Scoreboard bench for round_controller with DISPLAY_CYCLES=4, MAX_GUESSES=3.
module tb_round_controller;
    import memmatrix_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    round_controller_if bus_if ();

    round_controller #(
        .DISPLAY_CYCLES (4),
        .MAX_GUESSES    (3),
        .LFSR_SEED      (8'hA5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    typedef struct {
        string      nm;
        int         cyc;
        logic [28:0] val;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    // Hand-maintained expected output image for the cycle after each stimulus.
    logic [7:0] e_sol, e_found, cur_pred;
    logic [3:0] e_gl, e_lvl;
    logic [4:0] e_flags;   // {show, flash, win, lose, busy}

    // Reference pattern generator tracking the free-running LFSR phase.
    logic [7:0] m;
    function automatic logic [7:0] nxt(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset) m <= 8'hA5;
        else        m <= nxt(m);
    end

    // Monitor: compare every expectation due in the cycle just completed.
    always @(negedge clk) begin
        logic [28:0] got;
        got = {bus_if.solution_board, bus_if.found_board, bus_if.guesses_left,
               bus_if.level, bus_if.show_solution, bus_if.flash_en,
               bus_if.win, bus_if.lose, bus_if.busy};
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            if (e.cyc != cyc || got !== e.val) begin
                miscompares++;
                $display("FAIL %s cyc=%0d: got sol=%h found=%h gl=%0d lvl=%0d flags=%b, want sol=%h found=%h gl=%0d lvl=%0d flags=%b",
                         e.nm, cyc, got[28:21], got[20:13], got[12:9], got[8:5], got[4:0],
                         e.val[28:21], e.val[20:13], e.val[12:9], e.val[8:5], e.val[4:0]);
            end else begin
                $display("ok   %s cyc=%0d sol=%h found=%h gl=%0d lvl=%0d flags=%b",
                         e.nm, cyc, got[28:21], got[20:13], got[12:9], got[8:5], got[4:0]);
            end
        end
    end

    task automatic set_st(input state_t st);
        case (st)
            ST_IDLE: e_flags = 5'b01000;
            ST_LOAD: e_flags = 5'b00001;
            ST_SHOW: e_flags = 5'b10001;
            ST_PLAY: e_flags = 5'b00001;
            ST_WIN:  e_flags = 5'b01100;
            default: e_flags = 5'b11010;
        endcase
    endtask

    // Drive inputs for one cycle and queue the expected post-edge outputs.
    task automatic apply(input logic s, input logic [7:0] b, input string nm);
        exp_t e;
        bus_if.start     = s;
        bus_if.guess_btn = b;
        e.nm  = nm;
        e.cyc = cyc + 1;
        e.val = {e_sol, e_found, e_gl, e_lvl, e_flags};
        q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic press(input logic s, input logic [7:0] b, input string nm);
        apply(s, b, nm);
        apply(1'b0, 8'h00, {nm, "_rel"});
    endtask

    task automatic expect_reset_vals();
        e_sol = 8'h00; e_found = 8'h00; e_gl = 4'd3; e_lvl = 4'd0;
        set_st(ST_IDLE);
    endtask

    // Idle until the LFSR phase will load tgt on the next start.
    task automatic wait_phase(input logic [7:0] tgt);
        bit found;
        found = 0;
        for (int i = 0; i < 300; i++) begin
            if (nxt(m) == tgt) begin
                found = 1;
                break;
            end
            apply(1'b0, 8'h00, "wait");
        end
        if (!found) begin
            miscompares++;
            $display("FAIL wait_phase: got no phase for %h, want one within 300 cycles", tgt);
        end
    endtask

    // Start edge, one LOAD cycle, four SHOW cycles, then PLAY.
    task automatic begin_round(input bit poke);
        cur_pred = nxt(m);
        set_st(ST_LOAD);
        apply(1'b1, 8'h00, "load");
        e_sol = cur_pred; e_found = 8'h00; e_gl = 4'd3;
        set_st(ST_SHOW);
        for (int i = 0; i < 4; i++)
            apply(poke && (i == 1), (i == 2) ? 8'h01 : 8'h00, "show");
        set_st(ST_PLAY);
        apply(1'b0, 8'h00, "play_entry");
    endtask

    task automatic win_round(input bit poke);
        begin_round(poke);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] bit_m;
            bit_m = 8'h01 << i;
            if ((cur_pred & bit_m) != 8'h00) begin
                e_found = e_found | bit_m;
                if (e_found == cur_pred) begin
                    set_st(ST_WIN);
                    e_lvl = (e_lvl == 4'hF) ? 4'hF : e_lvl + 4'd1;
                end
                press(poke, bit_m, "hit");
            end
        end
    endtask

    initial begin
        bus_if.start = 1'b0;
        bus_if.guess_btn = 8'h00;
        reset = 1'b0;
        @(negedge clk);
        #1;
        expect_reset_vals();
        apply(1'b0, 8'h00, "reset");
        apply(1'b0, 8'h00, "reset_hold");
        reset = 1'b1;
        apply(1'b0, 8'h00, "idle");

        // Solution 05: chord, hit, re-press, final hit.
        wait_phase(8'h05);
        begin_round(1'b0);
        press(1'b0, 8'h03, "two_btn");
        e_found = 8'h01;
        press(1'b0, 8'h01, "hit_b0");
        press(1'b0, 8'h01, "repress_b0");
        e_found = 8'h05; e_lvl = 4'd1; set_st(ST_WIN);
        press(1'b0, 8'h04, "hit_b2_win");

        // Misses: held button counted once, third miss loses.
        wait_phase(8'h05);
        begin_round(1'b0);
        e_gl = 4'd2;
        for (int i = 0; i < 10; i++) apply(1'b0, 8'h02, "hold");
        apply(1'b0, 8'h00, "hold_rel");
        e_gl = 4'd1;
        press(1'b0, 8'h08, "miss2");
        e_gl = 4'd0; set_st(ST_LOSE);
        press(1'b0, 8'h10, "miss3_lose");
        press(1'b0, 8'h01, "lose_btn_ignored");
        e_lvl = 4'd0; set_st(ST_IDLE);
        apply(1'b1, 8'h00, "lose_to_idle");
        apply(1'b0, 8'h00, "idle2");

        // One win for a nonzero level, then reset in the middle of SHOW.
        win_round(1'b0);
        cur_pred = nxt(m);
        set_st(ST_LOAD);
        apply(1'b1, 8'h00, "load_r");
        e_sol = cur_pred; e_found = 8'h00; e_gl = 4'd3; set_st(ST_SHOW);
        apply(1'b0, 8'h00, "show_r");
        apply(1'b0, 8'h00, "show_r");
        reset = 1'b0;
        expect_reset_vals();
        apply(1'b0, 8'h00, "rst_mid_show");
        reset = 1'b1;
        apply(1'b0, 8'h00, "idle_after_rst");

        // Sixteen wins with start pokes during SHOW and PLAY.
        for (int r = 0; r < 16; r++) win_round(1'b1);
        apply(1'b0, 8'h00, "tail");

        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no completion, want finish before 2 ms");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/round_controller.md
Name: round_controller

Overview:
- Sequences one Memory Matrix round end to end: pattern generation, timed solution display, guess evaluation, and win/lose resolution.
- Owns the solution board, the found-tile board, the guess budget and the level counter.
- Drives the board-display block through show_solution, found_board and flash_en.
- Sits between the top-level button/key inputs and the display/LED logic.

Parameters:
- DISPLAY_CYCLES, 50_000_000: cycles the solution is shown before play starts (1 s at 50 MHz); must be >= 1.
- MAX_GUESSES, 3: wrong guesses allowed per round; range 1..15.
- LFSR_SEED, 8'hA5: LFSR reset value; a value of 0 is replaced by 8'h01.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low
- start  in  1  active-high level (inverted KEY[1]); rising edge detected internally
- guess_btn  in  8  active-high tile buttons; rising edges detected internally
- solution_board  out  8  pattern for the current round
- found_board  out  8  correctly guessed tiles so far
- show_solution  out  1  1 = display solution_board, 0 = display found_board
- flash_en  out  1  enables the status-LED flash
- guesses_left  out  4  remaining wrong guesses
- level  out  4  rounds won since last loss, saturating at 15
- win  out  1  high while in WIN
- lose  out  1  high while in LOSE
- busy  out  1  high in LOAD, SHOW and PLAY

Behaviour:
- Clock and reset: all flops use clk; reset is synchronous, active-low (reset==0).
- Reset values:
  - state=IDLE, solution_board=0, found_board=0, guesses_left=MAX_GUESSES, level=0.
  - lfsr=LFSR_SEED (01 if 0); start_q=0, btn_q=0, timer=0.
  - All 1-bit outputs 0, except flash_en=1 in IDLE.
- Edge detection:
  - start_edge = start & ~start_q.
  - press = guess_btn & ~btn_q.
  - start_q and btn_q are registered every cycle.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts every cycle in all states.
  - Never reaches 0. Player timing supplies the randomness.
- State machine (one state per cycle of evaluation):
  - IDLE: flash_en=1. On start_edge go to LOAD.
  - LOAD (1 cycle): solution_board<=lfsr, found_board<=0, guesses_left<=MAX_GUESSES, timer<=DISPLAY_CYCLES-1. Go to SHOW.
  - SHOW: show_solution=1. timer decrements each cycle. When timer==0, go to PLAY next cycle, so SHOW lasts exactly DISPLAY_CYCLES cycles. Presses are ignored.
  - PLAY: show_solution=0. A press is valid only if popcount(press)==1 and (press & found_board)==0. Non-one-hot or already-found presses are ignored with no penalty. For a valid press p, evaluated the same cycle with registered result next cycle:
    - Hit, (p & solution_board)!=0: found_board<=found_board|p. If (found_board|p)==solution_board, go to WIN.
    - Miss: guesses_left<=guesses_left-1. If guesses_left==1, go to LOSE; guesses_left reads 0 in LOSE.
  - WIN: win=1, flash_en=1. On entry, level<=level+1, saturating at 15. On start_edge go to LOAD (next round).
  - LOSE: lose=1, flash_en=1, show_solution=1. On start_edge: level<=0 and go to IDLE.
- start_edge in LOAD, SHOW or PLAY is ignored.
- Reset in any state, mid-round included, returns every register to its reset value on the next edge. Reset has priority over all other events.
- guesses_left never underflows: decrement happens only in PLAY, and only while the value is >= 1.

Decomposition:
- Package memmatrix_pkg:
  - 4-bit state encoding (IDLE=0, LOAD=1, SHOW=2, PLAY=3, WIN=4, LOSE=5).
  - LFSR tap mask 8'hB8.
  - BOARD_W=8.
- Sub-module lfsr8 (clk, reset, seed, q) with one free-running output.
- Edge detectors, timer and FSM stay inline.

Test Plan (DISPLAY_CYCLES=4, MAX_GUESSES=3, LFSR_SEED=8'hA5):
- Reset then start pulse:
  - LOAD one cycle after the edge, solution_board = LFSR value at the LOAD cycle.
  - show_solution=1 for exactly 4 cycles, then PLAY with found_board=0, guesses_left=3.
- Force solution=8'b0000_0101 via a known LFSR phase; press bit0 then bit2:
  - found_board = 01, then 05.
  - WIN next cycle, level=1, win=1.
- In PLAY, three presses on tiles outside the solution:
  - guesses_left 3->2->1.
  - Third press: LOSE, guesses_left=0, show_solution=1, lose=1.
  - start_edge -> IDLE, level=0.
- In PLAY:
  - Press two buttons simultaneously: no change.
  - Re-press an already-found tile: no change.
  - Hold a button across 10 cycles: counted once.
- Reset asserted mid-SHOW: next cycle state=IDLE, solution_board=0, guesses_left=3, flash_en=1.
- Sixteen consecutive wins: level saturates at 15; start during SHOW/PLAY has no effect.
